// File: rtl/mux_tdm_n.sv
// N-lane time-division serializer: captures a frame of LANES words and emits them one
// per valid/ready transfer, either every slot (fixed) or only the valid lanes (COMPACT).
module mux_tdm_n #(
    parameter int WIDTH   = 8,
    parameter int LANES   = 4,
    parameter int COMPACT = 0,
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_strobe,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_dvalid,
    output logic [LW-1:0]          out_lane,
    output logic                   out_last
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                        state_q, state_d;
    logic [LANES-1:0][WIDTH-1:0]   bank_q, bank_d;
    logic [LANES-1:0]              mask_q, mask_d;
    logic [LW-1:0]                 ptr_q, ptr_d;
    logic                          send, xfer, last_slot, accept;

    function automatic logic has_set_from(input logic [LANES-1:0] m, input int start);
        has_set_from = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= start && m[i]) has_set_from = 1'b1;
        end
    endfunction

    function automatic logic [LW-1:0] first_set_from(input logic [LANES-1:0] m, input int start);
        logic found;
        found          = 1'b0;
        first_set_from = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i >= start && m[i] && !found) begin
                first_set_from = LW'(i);
                found          = 1'b1;
            end
        end
    endfunction

    always_comb begin
        send = (state_q == SEND);
        xfer = send && out_ready;
        if (COMPACT != 0) begin
            last_slot = !has_set_from(mask_q, int'(ptr_q) + 1);
        end else begin
            last_slot = (ptr_q == LW'(LANES - 1));
        end
        // A new frame may load on the same edge that retires the last slot of the old one.
        in_ready = !reset && (!send || (xfer && last_slot));
        accept   = in_strobe && in_ready;
    end

    always_comb begin
        // NOTE: every _d starts from its held value, so no branch can leave it unassigned and infer a latch.
        state_d = state_q;
        bank_d  = bank_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        if (accept) begin
            bank_d = in_data;
            mask_d = in_valid;
            if (COMPACT != 0) begin
                ptr_d   = first_set_from(in_valid, 0);
                state_d = (in_valid != '0) ? SEND : IDLE;
            end else begin
                ptr_d   = '0;
                state_d = SEND;
            end
        end else if (xfer) begin
            if (last_slot) begin
                state_d = IDLE;
                ptr_d   = '0;
            end else if (COMPACT != 0) begin
                ptr_d = first_set_from(mask_q, int'(ptr_q) + 1);
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers take <= only; the combinational next-state logic above uses =.
        if (reset) begin
            state_q <= IDLE;
            // NOTE: the bank is a small register file, not a RAM, so clearing it on reset is legitimate.
            bank_q  <= '0;
            mask_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        out_valid  = send;
        out_data   = send ? bank_q[ptr_q] : '0;
        out_dvalid = send ? ((COMPACT != 0) ? 1'b1 : mask_q[ptr_q]) : 1'b0;
        out_lane   = send ? ptr_q : '0;
        out_last   = send && last_slot;
    end

endmodule
